ps16_bus_sequencer: RTL and testbench
=====================================

// Module: ps16_bus_sequencer
// PURPOSE
//  Sequences Pi-issued 68k transfers onto the 16-bit bus-cycle engine. Accepts one request
//  (byte/word/long), checks alignment, splits longs into two word cycles, drives lane strobes,
//  reruns on BERR+HALT, aborts on DTACK timeout, returns one response. Sits between the Pi
//  register interface and the bus-cycle state machine.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  sys_clk cycles from cyc_start with no cyc_done before abort
//  MAX_RETRY       2     reruns allowed per word cycle on BERR+HALT
// PORTS
//  sys_clk      in   1   system clock (PLL); sole clock
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present; accepted when req_valid & req_ready
//  req_ready    out  1   high only in IDLE
//  req_addr     in   24  byte address
//  req_size     in   2   0=byte 1=word 2=long 3=reserved
//  req_read     in   1   1=read 0=write
//  req_fc       in   3   function code
//  req_wdata    in   32  write data; byte in [7:0], word in [15:0], long in [31:0]
//  rsp_valid    out  1   one-cycle response pulse
//  rsp_rdata    out  32  read data, held until next rsp_valid
//  rsp_status   out  2   0=OK 1=BERR 2=MISALIGN 3=TIMEOUT
//  busy         out  1   high from accept through rsp_valid cycle
//  cyc_start    out  1   one-cycle pulse: engine starts a word cycle with cyc_* fields
//  cyc_addr     out  24  cycle address, bit0 forced 0 for word cycles
//  cyc_read     out  1   cycle direction
//  cyc_fc       out  3   cycle function code
//  cyc_uds      out  1   upper lane (D15:8) strobe enable
//  cyc_lds      out  1   lower lane (D7:0) strobe enable
//  cyc_wdata    out  16  cycle write data
//  cyc_abort    out  1   one-cycle pulse: engine releases bus, returns to idle
//  cyc_done     in   1   one-cycle pulse: cycle terminated (DTACK or BERR)
//  cyc_rdata    in   16  read data, valid with cyc_done
//  cyc_berr     in   1   qualifies cyc_done: terminated by BERR
//  cyc_halt     in   1   qualifies cyc_berr: HALT also asserted -> rerun
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 after reset cycle; rsp_valid, cyc_start, cyc_abort, busy=0;
//   rsp_rdata, rsp_status, cyc_* fields=0; retry count=0. Reset mid-transfer drops it, no response.
//  States: IDLE -> CHECK -> ISSUE -> WAIT -> (NEXT -> ISSUE) | RESPOND -> IDLE.
//  IDLE: on accept (cycle T) latch all req_* fields; -> CHECK.
//  CHECK (T+1): size 3, or size!=0 with addr[0]=1 -> RESPOND status MISALIGN; else -> ISSUE.
//  ISSUE: cyc_start pulse (T+2 for first cycle), fields valid from this cycle until cyc_done;
//   start timeout counter; -> WAIT.
//  Lanes: byte addr[0]=0 -> uds only, addr[0]=1 -> lds only, wdata[7:0] on both halves of cyc_wdata;
//   word/long -> uds & lds. Long: 1st cycle addr, wdata[31:16]; 2nd cycle (addr+2) mod 2^24,
//   wdata[15:0] (0xFFFFFE wraps to 0x000000).
//  Read data: byte -> rsp_rdata[7:0] from selected lane, [31:8]=0; word -> [15:0], [31:16]=0;
//   long -> 1st cycle to [31:16], 2nd to [15:0].
//  WAIT, cyc_done: berr&halt & count<MAX_RETRY -> count++, -> ISSUE (same fields);
//   berr otherwise -> RESPOND BERR (long aborted in 1st half: 2nd cycle not run, [31:16] invalid, [15:0]=0);
//   ok & long 1st half -> NEXT (count=0, 2nd cyc_start exactly 2 cycles after 1st cyc_done); ok otherwise -> RESPOND OK.
//  WAIT timeout: counter reaches TIMEOUT_CYCLES-1 with no cyc_done -> cyc_abort pulse, RESPOND TIMEOUT.
//   cyc_done in same cycle as timeout: cyc_done wins, no abort.
//  RESPOND: rsp_valid=1 for one cycle (cycle after final cyc_done); -> IDLE; req_ready=1 next cycle.
//  req_valid while busy ignored (no queueing). cyc_done outside WAIT ignored.
//  Counters: timeout width $clog2(TIMEOUT_CYCLES+1); retry width $clog2(MAX_RETRY+1).
// STRUCTURE
//  ps16_bus_pkg: size codes, status codes, state enum, lane-select function.
//  Sub-module ps16_watchdog: load/clear/expire counter, param TIMEOUT_CYCLES; rest inline.
// TESTING
//  Byte read 0x00BFE001: cyc_lds=1 cyc_uds=0, cyc_rdata=0x12AB -> rsp_rdata=0x000000AB, OK.
//  Long write 0xFFFFFE data 0xDEADBEEF: cycles 0xFFFFFE/0xDEAD then 0x000000/0xBEEF, OK.
//  Long read: 1st done berr=1 halt=1 twice then ok, 2nd ok -> 4 cyc_start total, OK; third BERR+HALT -> BERR.
//  Word read 0x000001 -> rsp_status=MISALIGN at T+2, zero cyc_start pulses.
//  No cyc_done for TIMEOUT_CYCLES (bench 16) -> cyc_abort pulse, TIMEOUT; done coincident with expiry -> OK.
//  rst during WAIT of long read -> no rsp_valid, req_ready=1, next request completes normally.

Source files
------------

// File: rtl/ps16_bus_pkg.sv
// ps16_bus_pkg
//   Shared definitions for the 68k bus sequencer slice:
//   - request size codes (byte/word/long/reserved)
//   - response status codes (OK/BERR/MISALIGN/TIMEOUT)
//   - sequencer state enum
//   - lane-select and alignment helper functions
package ps16_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_WORD = 2'd1;
    localparam logic [1:0] SIZE_LONG = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [1:0] STAT_OK       = 2'd0;
    localparam logic [1:0] STAT_BERR     = 2'd1;
    localparam logic [1:0] STAT_MISALIGN = 2'd2;
    localparam logic [1:0] STAT_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_RESPOND = 3'd5
    } seq_state_e;

    // Returns {uds, lds}. Even byte addresses live on D15:8 (upper lane),
    // odd byte addresses on D7:0 (lower lane); word/long use both lanes.
    function automatic logic [1:0] lane_sel(input logic [1:0] size, input logic addr0);
        logic [1:0] lanes;
        if (size == SIZE_BYTE) begin
            lanes = addr0 ? 2'b01 : 2'b10;
        end else begin
            lanes = 2'b11;
        end
        return lanes;
    endfunction

    // Reserved size is treated as misaligned; word/long must be even.
    function automatic logic is_misaligned(input logic [1:0] size, input logic addr0);
        logic bad;
        if (size == SIZE_RSVD) begin
            bad = 1'b1;
        end else if (size != SIZE_BYTE) begin
            bad = addr0;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

endpackage

// File: rtl/ps16_watchdog.sv
// ps16_watchdog
//   Cycle counter guarding an outstanding bus cycle.
//   Ports:
//     sys_clk  in  system clock
//     rst      in  synchronous active-high reset
//     load     in  restart the count at zero on the next edge
//     run      in  advance the count by one (ignored while load is high)
//     expired  out high while the count equals TIMEOUT_CYCLES-1
//   With load asserted on the edge that enters the start cycle and run held
//   through the cycle, expired rises TIMEOUT_CYCLES-1 cycles after the start
//   cycle, i.e. on the last of TIMEOUT_CYCLES cycles counted from it.
module ps16_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             expired_s;

    // Terminal-count decode.
    always_comb begin
        expired_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Counter register: clear, restart, or advance until terminal count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run && !expired_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = expired_s;

endmodule

// File: rtl/ps16_bus_sequencer.sv
// ps16_bus_sequencer
//   Takes one Pi-issued 68k transfer (byte/word/long), checks alignment,
//   splits longs into two word cycles on the 16-bit bus-cycle engine,
//   drives lane strobes, reruns on BERR+HALT, aborts on DTACK timeout and
//   returns a single response.
//   Ports:
//     sys_clk, rst                   clock, synchronous active-high reset
//     req_valid/req_ready            request handshake (ready only in IDLE)
//     req_addr/size/read/fc/wdata    request fields, latched on accept
//     rsp_valid                      one-cycle response pulse
//     rsp_rdata/rsp_status           response data/status, held until next rsp_valid
//     busy                           transfer in progress
//     cyc_start                      one-cycle start pulse to the engine
//     cyc_addr/read/fc/uds/lds/wdata word-cycle fields, valid from cyc_start
//     cyc_abort                      one-cycle abort pulse to the engine
//     cyc_done/rdata/berr/halt       cycle termination from the engine
module ps16_bus_sequencer
    import ps16_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_read,
    input  logic [2:0]  req_fc,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic        cyc_start,
    output logic [23:0] cyc_addr,
    output logic        cyc_read,
    output logic [2:0]  cyc_fc,
    output logic        cyc_uds,
    output logic        cyc_lds,
    output logic [15:0] cyc_wdata,
    output logic        cyc_abort,
    input  logic        cyc_done,
    input  logic [15:0] cyc_rdata,
    input  logic        cyc_berr,
    input  logic        cyc_halt
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    seq_state_e         state_r;
    seq_state_e         state_nx_s;

    // Latched request.
    logic [23:0]        addr_r;
    logic [1:0]         size_r;
    logic               read_r;
    logic [2:0]         fc_r;
    logic [31:0]        wdata_r;

    // Transfer bookkeeping.
    logic               half_r;
    logic               half_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_s;
    logic [31:0]        acc_r;
    logic [31:0]        acc_s;
    logic [1:0]         status_s;
    logic               abort_s;
    logic               accept_s;

    // Watchdog hookup.
    logic               wd_load_s;
    logic               wd_run_s;
    logic               wd_expired_s;

    // Next word-cycle fields.
    logic [23:0]        nx_addr_s;
    logic [15:0]        nx_wdata_s;
    logic [1:0]         nx_lanes_s;
    logic [23:0]        addr_plus2_s;
    logic [7:0]         byte_lane_s;

    // Registered outputs.
    logic               req_ready_r;
    logic               rsp_valid_r;
    logic [31:0]        rsp_rdata_r;
    logic [1:0]         rsp_status_r;
    logic               busy_r;
    logic               cyc_start_r;
    logic [23:0]        cyc_addr_r;
    logic               cyc_read_r;
    logic [2:0]         cyc_fc_r;
    logic               cyc_uds_r;
    logic               cyc_lds_r;
    logic [15:0]        cyc_wdata_r;
    logic               cyc_abort_r;

    ps16_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .sys_clk (sys_clk),
        .rst     (rst),
        .load    (wd_load_s),
        .run     (wd_run_s),
        .expired (wd_expired_s)
    );

    // Word-cycle field generation from the latched request and current half.
    always_comb begin
        addr_plus2_s = addr_r + 24'd2;
        nx_lanes_s   = lane_sel(size_r, addr_r[0]);
        byte_lane_s  = addr_r[0] ? cyc_rdata[7:0] : cyc_rdata[15:8];
        case (size_r)
            SIZE_BYTE: begin
                // Byte cycles keep A0 for reference; the strobes pick the lane.
                nx_addr_s  = addr_r;
                nx_wdata_s = {wdata_r[7:0], wdata_r[7:0]};
            end
            SIZE_LONG: begin
                if (half_r) begin
                    // Second half wraps naturally at the top of the 24-bit space.
                    nx_addr_s  = {addr_plus2_s[23:1], 1'b0};
                    nx_wdata_s = wdata_r[15:0];
                end else begin
                    nx_addr_s  = {addr_r[23:1], 1'b0};
                    nx_wdata_s = wdata_r[31:16];
                end
            end
            default: begin
                nx_addr_s  = {addr_r[23:1], 1'b0};
                nx_wdata_s = wdata_r[15:0];
            end
        endcase
    end

    // Next-state, retry, half and read-data accumulation logic.
    always_comb begin
        state_nx_s = state_r;
        half_s     = half_r;
        retry_s    = retry_r;
        acc_s      = acc_r;
        status_s   = rsp_status_r;
        abort_s    = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                half_s  = 1'b0;
                retry_s = {RETRY_W{1'b0}};
                acc_s   = 32'h0000_0000;
                if (req_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_CHECK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (is_misaligned(size_r, addr_r[0])) begin
                    status_s   = STAT_MISALIGN;
                    state_nx_s = ST_RESPOND;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A termination seen on the expiry cycle takes priority over the abort.
                if (cyc_done) begin
                    if (cyc_berr) begin
                        if (cyc_halt && (retry_r < RETRY_W'(MAX_RETRY))) begin
                            retry_s    = retry_r + RETRY_W'(1);
                            state_nx_s = ST_ISSUE;
                        end else begin
                            acc_s[15:0] = 16'h0000;
                            status_s    = STAT_BERR;
                            state_nx_s  = ST_RESPOND;
                        end
                    end else begin
                        if (read_r) begin
                            case (size_r)
                                SIZE_BYTE: acc_s = {24'h00_0000, byte_lane_s};
                                SIZE_WORD: acc_s = {16'h0000, cyc_rdata};
                                SIZE_LONG: begin
                                    if (half_r) begin
                                        acc_s[15:0] = cyc_rdata;
                                    end else begin
                                        acc_s[31:16] = cyc_rdata;
                                    end
                                end
                                default: acc_s = acc_r;
                            endcase
                        end else begin
                            acc_s = acc_r;
                        end
                        if ((size_r == SIZE_LONG) && !half_r) begin
                            half_s     = 1'b1;
                            retry_s    = {RETRY_W{1'b0}};
                            state_nx_s = ST_NEXT;
                        end else begin
                            status_s   = STAT_OK;
                            state_nx_s = ST_RESPOND;
                        end
                    end
                end else if (wd_expired_s) begin
                    abort_s    = 1'b1;
                    status_s   = STAT_TIMEOUT;
                    state_nx_s = ST_RESPOND;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                state_nx_s = ST_ISSUE;
            end
            ST_RESPOND: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Watchdog restarts on every entry to ISSUE and runs while a cycle is out.
    always_comb begin
        wd_load_s = (state_nx_s == ST_ISSUE);
        wd_run_s  = (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Request latch, bookkeeping and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            addr_r       <= 24'h00_0000;
            size_r       <= 2'd0;
            read_r       <= 1'b0;
            fc_r         <= 3'd0;
            wdata_r      <= 32'h0000_0000;
            half_r       <= 1'b0;
            retry_r      <= {RETRY_W{1'b0}};
            acc_r        <= 32'h0000_0000;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'h0000_0000;
            rsp_status_r <= 2'd0;
            busy_r       <= 1'b0;
            cyc_start_r  <= 1'b0;
            cyc_addr_r   <= 24'h00_0000;
            cyc_read_r   <= 1'b0;
            cyc_fc_r     <= 3'd0;
            cyc_uds_r    <= 1'b0;
            cyc_lds_r    <= 1'b0;
            cyc_wdata_r  <= 16'h0000;
            cyc_abort_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r  <= req_addr;
                size_r  <= req_size;
                read_r  <= req_read;
                fc_r    <= req_fc;
                wdata_r <= req_wdata;
            end else begin
                addr_r  <= addr_r;
                size_r  <= size_r;
                read_r  <= read_r;
                fc_r    <= fc_r;
                wdata_r <= wdata_r;
            end
            half_r      <= half_s;
            retry_r     <= retry_s;
            acc_r       <= acc_s;
            req_ready_r <= (state_nx_s == ST_IDLE);
            busy_r      <= (state_nx_s != ST_IDLE);
            cyc_start_r <= (state_nx_s == ST_ISSUE);
            rsp_valid_r <= (state_nx_s == ST_RESPOND);
            cyc_abort_r <= abort_s;
            if (state_nx_s == ST_RESPOND) begin
                rsp_status_r <= status_s;
                rsp_rdata_r  <= acc_s;
            end else begin
                rsp_status_r <= rsp_status_r;
                rsp_rdata_r  <= rsp_rdata_r;
            end
            // Fields are loaded with the start pulse and held until the next start.
            if (state_nx_s == ST_ISSUE) begin
                cyc_addr_r  <= nx_addr_s;
                cyc_read_r  <= read_r;
                cyc_fc_r    <= fc_r;
                cyc_uds_r   <= nx_lanes_s[1];
                cyc_lds_r   <= nx_lanes_s[0];
                cyc_wdata_r <= nx_wdata_s;
            end else begin
                cyc_addr_r  <= cyc_addr_r;
                cyc_read_r  <= cyc_read_r;
                cyc_fc_r    <= cyc_fc_r;
                cyc_uds_r   <= cyc_uds_r;
                cyc_lds_r   <= cyc_lds_r;
                cyc_wdata_r <= cyc_wdata_r;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_status = rsp_status_r;
    assign busy       = busy_r;
    assign cyc_start  = cyc_start_r;
    assign cyc_addr   = cyc_addr_r;
    assign cyc_read   = cyc_read_r;
    assign cyc_fc     = cyc_fc_r;
    assign cyc_uds    = cyc_uds_r;
    assign cyc_lds    = cyc_lds_r;
    assign cyc_wdata  = cyc_wdata_r;
    assign cyc_abort  = cyc_abort_r;

endmodule

// File: tb/tb_ps16_bus_sequencer.sv
// tb_ps16_bus_sequencer
//   Directed bench for ps16_bus_sequencer with TIMEOUT_CYCLES=16, MAX_RETRY=2.
//   The bench plays the bus-cycle engine by hand; expected values are
//   hand-computed constants.
module tb_ps16_bus_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'h00_0000;
    logic [1:0]  req_size = 2'd0;
    logic        req_read = 1'b0;
    logic [2:0]  req_fc = 3'd0;
    logic [31:0] req_wdata = 32'h0000_0000;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        busy;
    logic        cyc_start;
    logic [23:0] cyc_addr;
    logic        cyc_read;
    logic [2:0]  cyc_fc;
    logic        cyc_uds;
    logic        cyc_lds;
    logic [15:0] cyc_wdata;
    logic        cyc_abort;
    logic        cyc_done = 1'b0;
    logic [15:0] cyc_rdata = 16'h0000;
    logic        cyc_berr = 1'b0;
    logic        cyc_halt = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_start  = 0;
    int n_rsp    = 0;
    int s0;
    int r0;

    always #5 sys_clk = ~sys_clk;

    ps16_bus_sequencer #(
        .TIMEOUT_CYCLES (16),
        .MAX_RETRY      (2)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_read   (req_read),
        .req_fc     (req_fc),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .busy       (busy),
        .cyc_start  (cyc_start),
        .cyc_addr   (cyc_addr),
        .cyc_read   (cyc_read),
        .cyc_fc     (cyc_fc),
        .cyc_uds    (cyc_uds),
        .cyc_lds    (cyc_lds),
        .cyc_wdata  (cyc_wdata),
        .cyc_abort  (cyc_abort),
        .cyc_done   (cyc_done),
        .cyc_rdata  (cyc_rdata),
        .cyc_berr   (cyc_berr),
        .cyc_halt   (cyc_halt)
    );

    // Pulse monitors sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (cyc_start) n_start <= n_start + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_req(input logic [23:0] a, input logic [1:0] sz, input logic rd,
                            input logic [2:0] fc, input logic [31:0] wd);
        req_addr  = a;
        req_size  = sz;
        req_read  = rd;
        req_fc    = fc;
        req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int i;
        i = 0;
        while (!cyc_start && i < 40) begin
            tick();
            i++;
        end
        check_eq({tag, "_start_seen"}, {31'd0, cyc_start}, 32'd1);
    endtask

    task automatic pulse_done(input logic [15:0] rd, input logic be, input logic ht);
        cyc_rdata = rd;
        cyc_berr  = be;
        cyc_halt  = ht;
        cyc_done  = 1'b1;
        tick();
        cyc_done  = 1'b0;
        cyc_berr  = 1'b0;
        cyc_halt  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_cyc_start", {31'd0, cyc_start}, 32'd0);
        check_eq("rst_cyc_abort", {31'd0, cyc_abort}, 32'd0);
        check_eq("rst_status", {30'd0, rsp_status}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_cyc_addr", {8'd0, cyc_addr}, 32'd0);
        tick();

        // Byte read at odd address: lower lane only
        s0 = n_start;
        send_req(24'hBF_E001, 2'd0, 1'b1, 3'd1, 32'd0);
        check_eq("b_busy_t1", {31'd0, busy}, 32'd1);
        check_eq("b_start_t1", {31'd0, cyc_start}, 32'd0);
        tick();
        check_eq("b_start_t2", {31'd0, cyc_start}, 32'd1);
        check_eq("b_addr", {8'd0, cyc_addr}, 32'h00BF_E001);
        check_eq("b_lanes", {30'd0, cyc_uds, cyc_lds}, 32'b01);
        check_eq("b_read", {31'd0, cyc_read}, 32'd1);
        check_eq("b_fc", {29'd0, cyc_fc}, 32'd1);
        req_addr  = 24'h00_0002;
        req_size  = 2'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("b_start_pulse", {31'd0, cyc_start}, 32'd0);
        check_eq("b_ready_busy", {31'd0, req_ready}, 32'd0);
        pulse_done(16'h12AB, 1'b0, 1'b0);
        check_eq("b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("b_rdata", rsp_rdata, 32'h0000_00AB);
        check_eq("b_status", {30'd0, rsp_status}, 32'd0);
        check_eq("b_busy_rsp", {31'd0, busy}, 32'd1);
        tick();
        check_eq("b_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check_eq("b_ready_after", {31'd0, req_ready}, 32'd1);
        check_eq("b_busy_after", {31'd0, busy}, 32'd0);
        check_eq("b_rdata_hold", rsp_rdata, 32'h0000_00AB);
        check_eq("b_one_start", n_start - s0, 32'd1);

        // Long write wrapping at the top of the address space
        send_req(24'hFF_FFFE, 2'd2, 1'b0, 3'd5, 32'hDEAD_BEEF);
        wait_start("lw1");
        check_eq("lw1_addr", {8'd0, cyc_addr}, 32'h00FF_FFFE);
        check_eq("lw1_wdata", {16'd0, cyc_wdata}, 32'h0000_DEAD);
        check_eq("lw1_lanes", {30'd0, cyc_uds, cyc_lds}, 32'b11);
        check_eq("lw1_read", {31'd0, cyc_read}, 32'd0);
        tick();
        pulse_done(16'h0000, 1'b0, 1'b0);
        check_eq("lw_gap_start", {31'd0, cyc_start}, 32'd0);
        check_eq("lw_gap_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq("lw2_start", {31'd0, cyc_start}, 32'd1);
        check_eq("lw2_addr", {8'd0, cyc_addr}, 32'h0000_0000);
        check_eq("lw2_wdata", {16'd0, cyc_wdata}, 32'h0000_BEEF);
        tick();
        pulse_done(16'h0000, 1'b0, 1'b0);
        check_eq("lw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("lw_status", {30'd0, rsp_status}, 32'd0);
        tick();

        // Long read, two reruns on the first half then success
        s0 = n_start;
        send_req(24'h00_1000, 2'd2, 1'b1, 3'd2, 32'd0);
        wait_start("lr");
        tick();
        pulse_done(16'hFFFF, 1'b1, 1'b1);
        check_eq("lr_retry1_start", {31'd0, cyc_start}, 32'd1);
        check_eq("lr_retry1_addr", {8'd0, cyc_addr}, 32'h0000_1000);
        tick();
        pulse_done(16'hFFFF, 1'b1, 1'b1);
        check_eq("lr_retry2_start", {31'd0, cyc_start}, 32'd1);
        tick();
        pulse_done(16'h1234, 1'b0, 1'b0);
        tick();
        check_eq("lr2_start", {31'd0, cyc_start}, 32'd1);
        check_eq("lr2_addr", {8'd0, cyc_addr}, 32'h0000_1002);
        tick();
        pulse_done(16'h5678, 1'b0, 1'b0);
        check_eq("lr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("lr_rdata", rsp_rdata, 32'h1234_5678);
        check_eq("lr_status", {30'd0, rsp_status}, 32'd0);
        check_eq("lr_starts", n_start - s0, 32'd4);
        tick();

        // Long read, third BERR+HALT gives up
        s0 = n_start;
        send_req(24'h00_2000, 2'd2, 1'b1, 3'd2, 32'd0);
        wait_start("lb");
        for (int i = 0; i < 3; i++) begin
            tick();
            pulse_done(16'hAAAA, 1'b1, 1'b1);
        end
        check_eq("lb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("lb_status", {30'd0, rsp_status}, 32'd1);
        check_eq("lb_rdata_low", {16'd0, rsp_rdata[15:0]}, 32'd0);
        check_eq("lb_starts", n_start - s0, 32'd3);
        tick();

        // Word read at odd address
        s0 = n_start;
        send_req(24'h00_0001, 2'd1, 1'b1, 3'd1, 32'd0);
        check_eq("mw_rsp_t1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq("mw_rsp_t2", {31'd0, rsp_valid}, 32'd1);
        check_eq("mw_status", {30'd0, rsp_status}, 32'd2);
        check_eq("mw_rdata", rsp_rdata, 32'd0);
        tick();
        // Reserved size
        send_req(24'h00_0000, 2'd3, 1'b1, 3'd1, 32'd0);
        tick();
        check_eq("mr_rsp_t2", {31'd0, rsp_valid}, 32'd1);
        check_eq("mr_status", {30'd0, rsp_status}, 32'd2);
        check_eq("m_no_starts", n_start - s0, 32'd0);
        tick();

        // Plain word read
        send_req(24'h00_0ABC, 2'd1, 1'b1, 3'd6, 32'd0);
        wait_start("wr");
        check_eq("wr_addr", {8'd0, cyc_addr}, 32'h0000_0ABC);
        check_eq("wr_lanes", {30'd0, cyc_uds, cyc_lds}, 32'b11);
        tick();
        pulse_done(16'hCAFE, 1'b0, 1'b0);
        check_eq("wr_rdata", rsp_rdata, 32'h0000_CAFE);
        check_eq("wr_status", {30'd0, rsp_status}, 32'd0);
        tick();

        // Timeout with no termination
        send_req(24'h00_0100, 2'd1, 1'b1, 3'd1, 32'd0);
        wait_start("to");
        repeat (15) tick();
        check_eq("to_abort_early", {31'd0, cyc_abort}, 32'd0);
        check_eq("to_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq("to_abort", {31'd0, cyc_abort}, 32'd1);
        check_eq("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("to_status", {30'd0, rsp_status}, 32'd3);
        tick();
        check_eq("to_abort_pulse", {31'd0, cyc_abort}, 32'd0);

        // Termination on the expiry cycle wins
        send_req(24'h00_0200, 2'd1, 1'b0, 3'd1, 32'h0000_1111);
        wait_start("tc");
        repeat (15) tick();
        pulse_done(16'h0000, 1'b0, 1'b0);
        check_eq("tc_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("tc_status", {30'd0, rsp_status}, 32'd0);
        check_eq("tc_no_abort", {31'd0, cyc_abort}, 32'd0);
        tick();

        // Reset during WAIT of a long read
        send_req(24'h00_3000, 2'd2, 1'b1, 3'd2, 32'd0);
        wait_start("rs");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r0 = n_rsp;
        check_eq("rs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rs_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rs_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check_eq("rs_no_rsp", n_rsp - r0, 32'd0);
        send_req(24'h00_0010, 2'd0, 1'b0, 3'd5, 32'h0000_005A);
        wait_start("rs_next");
        check_eq("rs_next_lanes", {30'd0, cyc_uds, cyc_lds}, 32'b10);
        check_eq("rs_next_wdata", {16'd0, cyc_wdata}, 32'h0000_5A5A);
        check_eq("rs_next_addr", {8'd0, cyc_addr}, 32'h0000_0010);
        tick();
        pulse_done(16'h0000, 1'b0, 1'b0);
        check_eq("rs_next_rsp", {31'd0, rsp_valid}, 32'd1);
        check_eq("rs_next_status", {30'd0, rsp_status}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
